uriscv_irq_ctrl: RTL

URISCV_IRQ_CTRL -- requirements
Module: uriscv_irq_ctrl

---
 rtl/uriscv_irq_ctrl_pkg.sv | 17 +
 rtl/uriscv_irq_sync.sv | 30 +++
 rtl/uriscv_irq_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/uriscv_irq_ctrl_pkg.sv
// Shared definitions for the uriscv interrupt controller: register offsets
// and the claim/complete FSM state encoding.
package uriscv_irq_ctrl_pkg;

    localparam logic [4:0] IRQ_OFF_PENDING = 5'h00;
    localparam logic [4:0] IRQ_OFF_ENABLE  = 5'h04;
    localparam logic [4:0] IRQ_OFF_EDGE    = 5'h08;
    localparam logic [4:0] IRQ_OFF_VBASE   = 5'h0C;
    localparam logic [4:0] IRQ_OFF_CLAIM   = 5'h10;
    localparam logic [4:0] IRQ_OFF_INSVC   = 5'h14;

    typedef enum logic {
        IRQ_ST_IDLE    = 1'b0,
        IRQ_ST_SERVICE = 1'b1
    } irq_state_e;

endpackage

// File: rtl/uriscv_irq_sync.sv
// Per-source 2-flop synchronizer plus rising-edge detector on the
// synchronized level.
module uriscv_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= irq_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level_o = r_sync;
    assign rise_o  = r_sync & ~r_prev;

endmodule

// File: rtl/uriscv_irq_ctrl.sv
// Interrupt controller: pending/enable/edge registers, lowest-index priority,
// claim/complete handshake and vectored handler address.
module uriscv_irq_ctrl
    import uriscv_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               intr_o,
    output logic [31:0]        isr_vector_o
);

    localparam int PADW = 32 - NUM_IRQ;

    logic [NUM_IRQ-1:0] w_level, w_rise;
    logic [NUM_IRQ-1:0] r_pend, r_en, r_edge;
    logic [31:2]        r_vbase;
    irq_state_e         r_state;
    logic [4:0]         r_insvc;
    logic [31:0]        r_rdata;
    logic               r_ack;

    logic [NUM_IRQ-1:0] w_qual, w_win_mask, w_clr, w_pend_nxt;
    logic [4:0]         w_win_id;
    logic               w_wr, w_rd, w_claim_take, w_complete;
    logic [31:0]        w_rdata;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        uriscv_irq_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .irq_i   (irq_i[gi]),
            .level_o (w_level[gi]),
            .rise_o  (w_rise[gi])
        );
    end

    assign w_wr = req_i & we_i;
    assign w_rd = req_i & ~we_i;

    // Lowest set bit wins; one-hot mask is used for the claim clear.
    assign w_qual     = r_pend & r_en;
    assign w_win_mask = w_qual & ~(w_qual - NUM_IRQ'(1));

    always_comb begin
        w_win_id = '0;
        for (int n = NUM_IRQ - 1; n >= 0; n--)
            if (w_qual[n]) w_win_id = 5'(n + 1);
    end

    assign w_claim_take = w_rd && (addr_i == IRQ_OFF_CLAIM) &&
                          (r_state == IRQ_ST_IDLE) && (w_win_id != 5'd0);
    assign w_complete   = w_wr && (addr_i == IRQ_OFF_CLAIM) &&
                          (r_state == IRQ_ST_SERVICE) && (wdata_i[4:0] == r_insvc);

    // A fresh edge beats a same-cycle clear; level sources just track the input.
    assign w_clr = ((w_wr && addr_i == IRQ_OFF_PENDING) ? wdata_i[NUM_IRQ-1:0] : '0) |
                   (w_claim_take ? w_win_mask : '0);
    assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & w_level);

    always_comb begin
        w_rdata = '0;
        case (addr_i)
            IRQ_OFF_PENDING: w_rdata = {{PADW{1'b0}}, r_pend};
            IRQ_OFF_ENABLE:  w_rdata = {{PADW{1'b0}}, r_en};
            IRQ_OFF_EDGE:    w_rdata = {{PADW{1'b0}}, r_edge};
            IRQ_OFF_VBASE:   w_rdata = {r_vbase, 2'b00};
            IRQ_OFF_CLAIM:   w_rdata = w_claim_take ? {27'd0, w_win_id} : 32'd0;
            IRQ_OFF_INSVC:   w_rdata = {27'd0, r_insvc};
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_en    <= '0;
            r_edge  <= '0;
            r_vbase <= '0;
            r_state <= IRQ_ST_IDLE;
            r_insvc <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_ack  <= req_i;
            if (req_i) r_rdata <= w_rdata;
            if (w_wr && addr_i == IRQ_OFF_ENABLE) r_en    <= wdata_i[NUM_IRQ-1:0];
            if (w_wr && addr_i == IRQ_OFF_EDGE)   r_edge  <= wdata_i[NUM_IRQ-1:0];
            if (w_wr && addr_i == IRQ_OFF_VBASE)  r_vbase <= wdata_i[31:2];
            case (r_state)
                IRQ_ST_IDLE: if (w_claim_take) begin
                    r_state <= IRQ_ST_SERVICE;
                    r_insvc <= w_win_id;
                end
                IRQ_ST_SERVICE: if (w_complete) begin
                    r_state <= IRQ_ST_IDLE;
                    r_insvc <= '0;
                end
                default: r_state <= IRQ_ST_IDLE;
            endcase
        end
    end

    assign rdata_o      = r_rdata;
    assign ack_o        = r_ack;
    assign intr_o       = (r_state == IRQ_ST_IDLE) && (w_win_id != 5'd0);
    assign isr_vector_o = {r_vbase, 2'b00} + {25'd0, w_win_id, 2'b00};

endmodule
